aes_enc_key_ctrl: RTL and testbench
===================================

// Module: aes_enc_key_ctrl
// PURPOSE
// Sequences the AES-256 key expansion and encryption cores: loads new keys, holds plaintext until round keys are valid,
// and changes keys only at frame boundaries after the encryption pipeline has drained.
// Sits between the user key/data AXI-Stream ports and the key_expansion / aes_encryption instances.
// PARAMETERS
// TDATA_WIDTH     128   plaintext beat width
// KEY_WIDTH       256   AES key width
// MAX_INFLIGHT    16    max blocks accepted by the engine but not yet output (>= ROUND_NUMBER+2)
// MASK_CYCLES     2     cycles after key issue during which round_keys_valid_i is ignored
// EXP_TIMEOUT     1024  cycles allowed for key expansion before error
// PORTS
// clk                 in   1            clock
// resetn              in   1            async active-low reset
// key_tdata           in   KEY_WIDTH    new key
// key_tvalid          in   1            key offered
// key_tready          out  1            key accepted (in IDLE/RUN only, see below)
// s_tdata/tvalid/tlast in  128/1/1      user plaintext stream
// s_tready            out  1            user stream ready
// enc_tdata/tvalid/tlast out 128/1/1    to aes_encryption aes_in_*
// enc_tready          in   1            aes_in_tready
// enc_out_fire        in   1            aes_out_tvalid & aes_out_tready (one ciphertext beat retired)
// aes_key_o           out  KEY_WIDTH    to key_expansion aes_key_i
// aes_key_valid_o     out  1            to key_expansion aes_key_valid_i
// round_keys_valid_i  in   1            from key_expansion
// keys_loaded_o       out  1            engine holds valid round keys
// inflight_o          out  $clog2(MAX_INFLIGHT+1)  blocks in flight
// err_timeout_o       out  1            sticky expansion timeout
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE; key_tready=0 during reset, s_tready=0, enc_tvalid=0, aes_key_valid_o=0,
//   aes_key_o=0, keys_loaded_o=0, inflight_o=0, err_timeout_o=0. Reset mid-operation drops in-flight count; no recovery.
// - Data path is combinational pass-through: enc_tdata/tlast=s_tdata/tlast; enc_tvalid=s_tvalid&gate;
//   s_tready=enc_tready&gate; gate=(state==RUN)&(inflight_o<MAX_INFLIGHT)&~drain_req. Zero added latency.
// - States:
//   IDLE:   key_tready=1. key fire -> register key into aes_key_o, go EXPAND.
//   EXPAND: aes_key_valid_o=1 held; cycle counter from 0. round_keys_valid_i ignored while cnt<MASK_CYCLES;
//           then round_keys_valid_i=1 -> keys_loaded_o=1, go RUN (aes_key_valid_o stays 1, key stays stable).
//           cnt==EXP_TIMEOUT-1 without valid -> err_timeout_o=1 (sticky until reset), aes_key_valid_o=0, go IDLE.
//   RUN:    key_tready=~in_frame. key fire -> capture new key into pending reg, set drain_req, go DRAIN.
//   DRAIN:  gate=0 (no new beats); wait inflight_o==0 -> aes_key_o=pending, aes_key_valid_o pulses 0 for one cycle,
//           keys_loaded_o=0, go EXPAND.
// - in_frame: set on accepted beat with tlast=0, cleared on accepted beat with tlast=1. Key offered mid-frame is
//   back-pressured (key_tready=0) until the tlast beat is accepted; frames are never split across keys.
// - Inflight counter: +1 on enc_tvalid&enc_tready, -1 on enc_out_fire; both same cycle -> unchanged.
//   At MAX_INFLIGHT input stalls; enc_out_fire at 0 is a protocol error: counter saturates at 0 (no wrap).
// - key_tvalid and s_tvalid fire in same RUN cycle: beat accepted first, then DRAIN blocks subsequent beats.
// STRUCTURE
// - aes_parameters.svh: add ctrl_state_t enum {IDLE,EXPAND,RUN,DRAIN} and KEY_WIDTH/MAX_INFLIGHT defaults.
// - One sub-module: aes_inflight_counter (saturating up/down counter with full/empty flags).
// TESTING
// 1 Reset then key 603DEB10..0914DFF4 -> key_tready=1 in IDLE; keys_loaded_o=1 within EXP_TIMEOUT; s_tready=0 until then.
// 2 Plaintext 6BC1BEE22E409F96E93D7E117393172A after load -> ciphertext F3EED1BDB5D2A03C064B5A7E3DB181F8; inflight 1->0.
// 3 4-beat frame with new key offered after beat 1 -> key_tready=0 until tlast beat; DRAIN until inflight=0, then EXPAND.
// 4 aes_out_tready=0 held, stream 20 beats -> s_tready drops when inflight_o=16; resumes one beat per retired block.
// 5 round_keys_valid_i tied 0 -> err_timeout_o=1 after 1024 cycles, state IDLE, s_tready=0.
// 6 resetn pulsed low during DRAIN with 3 in flight -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/aes_enc_key_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// aes_enc_key_ctrl_pkg
// Shared defaults, controller state encoding and the debug status struct used
// by the AES-256 key/encryption sequencing controller and its bench.
// ----------------------------------------------------------------------------
package aes_enc_key_ctrl_pkg;

    localparam int TDATA_WIDTH_DEF  = 128;
    localparam int KEY_WIDTH_DEF    = 256;
    // Must cover the full encryption pipeline depth (14 rounds + 2).
    localparam int MAX_INFLIGHT_DEF = 16;
    localparam int MASK_CYCLES_DEF  = 2;
    localparam int EXP_TIMEOUT_DEF  = 1024;

    // Controller state encoding.
    typedef logic [1:0] ctrl_state_t;
    localparam ctrl_state_t ST_IDLE   = 2'd0;
    localparam ctrl_state_t ST_EXPAND = 2'd1;
    localparam ctrl_state_t ST_RUN    = 2'd2;
    localparam ctrl_state_t ST_DRAIN  = 2'd3;

    // Debug view of the controller internals.
    typedef struct packed {
        ctrl_state_t state;
        logic        in_frame;
        logic        drain_req;
    } ctrl_dbg_t;

endpackage

// File: rtl/aes_enc_key_ctrl_if.sv
// ----------------------------------------------------------------------------
// aes_enc_key_ctrl_if
// Groups the stream-side signals of the controller:
//   key_*      user key stream (KEY_WIDTH data, valid/ready)
//   s_*        user plaintext stream (TDATA_WIDTH data, valid/ready/last)
//   enc_*      plaintext towards the encryption engine input
//   enc_out_fire  one ciphertext beat retired by the engine output
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both 1. A source holds data/last stable and keeps valid asserted until
// the transfer; ready may change freely and may depend on valid.
// master: the user/engine side; slave: the controller.
// ----------------------------------------------------------------------------
interface aes_enc_key_ctrl_if
    import aes_enc_key_ctrl_pkg::*;
#(
    parameter int TDATA_WIDTH = TDATA_WIDTH_DEF,
    parameter int KEY_WIDTH   = KEY_WIDTH_DEF
);
    logic [KEY_WIDTH-1:0]   key_tdata;
    logic                   key_tvalid;
    logic                   key_tready;

    logic [TDATA_WIDTH-1:0] s_tdata;
    logic                   s_tvalid;
    logic                   s_tlast;
    logic                   s_tready;

    logic [TDATA_WIDTH-1:0] enc_tdata;
    logic                   enc_tvalid;
    logic                   enc_tlast;
    logic                   enc_tready;

    logic                   enc_out_fire;

    modport master (
        output key_tdata, key_tvalid, s_tdata, s_tvalid, s_tlast, enc_tready, enc_out_fire,
        input  key_tready, s_tready, enc_tdata, enc_tvalid, enc_tlast
    );

    modport slave (
        input  key_tdata, key_tvalid, s_tdata, s_tvalid, s_tlast, enc_tready, enc_out_fire,
        output key_tready, s_tready, enc_tdata, enc_tvalid, enc_tlast
    );
endinterface

// File: rtl/aes_enc_key_ctrl_inflight_counter.sv
// ----------------------------------------------------------------------------
// aes_inflight_counter
// Saturating up/down counter of blocks accepted by the encryption engine but
// not yet retired.
//   clk, rst_n   clock, async active-low reset
//   inc_i        one block accepted
//   dec_i        one block retired
//   count_o      current count (0..MAX_COUNT)
//   full_o       count == MAX_COUNT
//   empty_o      count == 0
// Simultaneous inc/dec leaves the count unchanged. A retire at zero is a
// protocol error and is absorbed (no wrap); an accept at MAX_COUNT is ignored.
// ----------------------------------------------------------------------------
module aes_inflight_counter
    import aes_enc_key_ctrl_pkg::*;
#(
    parameter  int MAX_COUNT = MAX_INFLIGHT_DEF,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != CW'(MAX_COUNT))) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CW'(MAX_COUNT));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/aes_enc_key_ctrl.sv
// ----------------------------------------------------------------------------
// aes_enc_key_ctrl
// Sequences AES-256 key expansion and the encryption engine: loads keys,
// holds plaintext until round keys are valid, and swaps keys only at frame
// boundaries once every in-flight block has left the engine.
//   clk, resetn         clock, async active-low reset
//   bus (slave)         key stream, plaintext stream, engine input stream,
//                       engine retire strobe
//   aes_key_o           key towards key expansion
//   aes_key_valid_o     key valid towards key expansion
//   round_keys_valid_i  round keys ready from key expansion
//   keys_loaded_o       engine holds valid round keys
//   inflight_o          blocks accepted by the engine and not yet retired
//   err_timeout_o       sticky key expansion timeout
//   dbg_o               state / in_frame / drain request
// The plaintext path is a zero-latency combinational pass-through gated by
// the controller state and the in-flight count.
// ----------------------------------------------------------------------------
module aes_enc_key_ctrl
    import aes_enc_key_ctrl_pkg::*;
#(
    parameter  int TDATA_WIDTH  = TDATA_WIDTH_DEF,
    parameter  int KEY_WIDTH    = KEY_WIDTH_DEF,
    parameter  int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter  int MASK_CYCLES  = MASK_CYCLES_DEF,
    parameter  int EXP_TIMEOUT  = EXP_TIMEOUT_DEF,
    localparam int IW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    aes_enc_key_ctrl_if.slave    bus,
    output logic [KEY_WIDTH-1:0] aes_key_o,
    output logic                 aes_key_valid_o,
    input  logic                 round_keys_valid_i,
    output logic                 keys_loaded_o,
    output logic [IW-1:0]        inflight_o,
    output logic                 err_timeout_o,
    output ctrl_dbg_t            dbg_o
);
    localparam int CNT_W = $clog2(EXP_TIMEOUT);

    ctrl_state_t          state_q,     state_d;
    logic [KEY_WIDTH-1:0] key_q,       key_d;
    logic [KEY_WIDTH-1:0] pend_q,      pend_d;
    logic                 key_valid_q, key_valid_d;
    logic                 loaded_q,    loaded_d;
    logic                 err_q,       err_d;
    logic                 in_frame_q,  in_frame_d;
    logic                 drain_req_q, drain_req_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;

    logic                   beat_gate;
    logic                   beat_fire;
    logic                   key_ready;
    logic                   key_fire;
    logic                   inflight_full;
    logic                   inflight_empty;
    logic [TDATA_WIDTH-1:0] beat_data;

    // Engine-side occupancy.
    aes_inflight_counter #(
        .MAX_COUNT (MAX_INFLIGHT)
    ) u_inflight (
        .clk     (clk),
        .rst_n   (resetn),
        .inc_i   (beat_fire),
        .dec_i   (bus.enc_out_fire),
        .count_o (inflight_o),
        .full_o  (inflight_full),
        .empty_o (inflight_empty)
    );

    // Plaintext pass-through.
    assign beat_gate      = (state_q == ST_RUN) && !inflight_full && !drain_req_q;
    assign beat_fire      = bus.s_tvalid && bus.enc_tready && beat_gate;
    assign beat_data      = bus.s_tdata;
    assign bus.enc_tdata  = beat_data;
    assign bus.enc_tlast  = bus.s_tlast;
    assign bus.enc_tvalid = bus.s_tvalid && beat_gate;
    assign bus.s_tready   = bus.enc_tready && beat_gate;

    // In RUN a key is only taken between frames. A first beat with tlast=0
    // accepted in this very cycle opens a frame, so the key is refused too;
    // otherwise the rest of that frame would go out under the new key.
    // resetn forces ready low while reset is held.
    assign key_ready = resetn &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_RUN) && !in_frame_q && !(beat_fire && !bus.s_tlast)));
    assign key_fire       = bus.key_tvalid && key_ready;
    assign bus.key_tready = key_ready;

    always_comb begin
        in_frame_d = in_frame_q;
        if (beat_fire) begin
            in_frame_d = !bus.s_tlast;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        pend_d      = pend_q;
        key_valid_d = key_valid_q;
        loaded_d    = loaded_q;
        err_d       = err_q;
        drain_req_d = drain_req_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (key_fire) begin
                    key_d       = bus.key_tdata;
                    key_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                // round_keys_valid_i may still reflect the previous key for
                // the first MASK_CYCLES cycles, so it is not trusted yet.
                key_valid_d = 1'b1;
                if ((cnt_q >= CNT_W'(MASK_CYCLES)) && round_keys_valid_i) begin
                    loaded_d = 1'b1;
                    state_d  = ST_RUN;
                end else if (cnt_q == CNT_W'(EXP_TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (key_fire) begin
                    pend_d      = bus.key_tdata;
                    drain_req_d = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The one-cycle drop of key valid makes key expansion see a
                // fresh key edge.
                if (inflight_empty) begin
                    key_d       = pend_q;
                    key_valid_d = 1'b0;
                    loaded_d    = 1'b0;
                    drain_req_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_EXPAND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            pend_q      <= '0;
            key_valid_q <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            in_frame_q  <= 1'b0;
            drain_req_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            pend_q      <= pend_d;
            key_valid_q <= key_valid_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            in_frame_q  <= in_frame_d;
            drain_req_q <= drain_req_d;
            cnt_q       <= cnt_d;
        end
    end

    assign aes_key_o       = key_q;
    assign aes_key_valid_o = key_valid_q;
    assign keys_loaded_o   = loaded_q;
    assign err_timeout_o   = err_q;

    always_comb begin
        dbg_o           = '0;
        dbg_o.state     = state_q;
        dbg_o.in_frame  = in_frame_q;
        dbg_o.drain_req = drain_req_q;
    end
endmodule

// File: tb/tb_aes_enc_key_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_enc_key_ctrl
// Bench for aes_enc_key_ctrl: reset values, key load with masked round-key
// valid, pass-through vectors, frame-boundary key change with drain, in-flight
// saturation, randomized traffic against a counting model, expansion timeout
// and asynchronous reset during DRAIN.
// ----------------------------------------------------------------------------
module tb_aes_enc_key_ctrl;
    import aes_enc_key_ctrl_pkg::*;

    localparam logic [255:0] K1 =
        256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
    localparam logic [127:0] PT = 128'h6BC1BEE22E409F96E93D7E117393172A;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic         rkv;
    logic [255:0] aes_key;
    logic         aes_key_valid;
    logic         keys_loaded;
    logic [4:0]   inflight;
    logic         err_timeout;
    ctrl_dbg_t    dbg;

    aes_enc_key_ctrl_if #(.TDATA_WIDTH(128), .KEY_WIDTH(256)) bus ();

    aes_enc_key_ctrl dut (
        .clk                (clk),
        .resetn             (resetn),
        .bus                (bus),
        .aes_key_o          (aes_key),
        .aes_key_valid_o    (aes_key_valid),
        .round_keys_valid_i (rkv),
        .keys_loaded_o      (keys_loaded),
        .inflight_o         (inflight),
        .err_timeout_o      (err_timeout),
        .dbg_o              (dbg)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [128:0] exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.key_tdata    = '0;
        bus.key_tvalid   = 1'b0;
        bus.s_tdata      = '0;
        bus.s_tvalid     = 1'b0;
        bus.s_tlast      = 1'b0;
        bus.enc_tready   = 1'b0;
        bus.enc_out_fire = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expects inputs offering a key and a beat so the ready outputs are meaningful.
    task automatic chk_reset(input string tag);
        chk({tag, "_key_tready"}, bus.key_tready, 0);
        chk({tag, "_s_tready"},   bus.s_tready,   0);
        chk({tag, "_enc_tvalid"}, bus.enc_tvalid, 0);
        chk({tag, "_aes_key"},    aes_key,        0);
        chk({tag, "_key_valid"},  aes_key_valid,  0);
        chk({tag, "_loaded"},     keys_loaded,    0);
        chk({tag, "_inflight"},   inflight,       0);
        chk({tag, "_err"},        err_timeout,    0);
        chk({tag, "_state"},      dbg.state,      ST_IDLE);
    endtask

    typedef struct {
        logic sv;     // s_tvalid
        logic sl;     // s_tlast
        logic er;     // enc_tready
        logic ev;     // expected enc_tvalid
        logic sr;     // expected s_tready
        logic kr;     // expected key_tready
    } vec_t;

    vec_t tbl[8];

    // ---------------- test sequence ----------------
    initial begin
        logic [255:0] k2;
        logic [127:0] d;
        int           m_inf;
        logic         m_in_frame;

        // Pass-through vectors, applied in RUN with in_frame=0, inflight=0.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        idle_inputs();
        rkv    = 1'b0;
        resetn = 1'b0;
        repeat (3) tick();

        // ---- T1: reset values, key load, masked round-key valid ----
        bus.enc_tready = 1'b1;
        bus.s_tvalid   = 1'b1;
        bus.key_tvalid = 1'b1;
        #1;
        chk_reset("t1_rst");
        resetn         = 1'b1;
        bus.s_tdata    = PT;
        bus.s_tlast    = 1'b1;
        bus.key_tdata  = K1;
        rkv            = 1'b1;   // held high: only honoured after the mask window
        #1;
        chk("t1_key_tready_idle", bus.key_tready, 1);
        chk("t1_s_tready_idle",   bus.s_tready,   0);
        tick();
        bus.key_tvalid = 1'b0;
        chk("t1_state_expand", dbg.state, ST_EXPAND);
        chk("t1_aes_key",      aes_key,   K1);
        chk("t1_key_valid",    aes_key_valid, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t1_loaded_masked", keys_loaded,    0);
            chk("t1_s_tready_hold", bus.s_tready,   0);
            chk("t1_enc_tvalid_hold", bus.enc_tvalid, 0);
            tick();
        end
        chk("t1_loaded",    keys_loaded, 1);
        chk("t1_state_run", dbg.state,   ST_RUN);

        // ---- T2: held plaintext passes through, inflight 1 -> 0 ----
        chk("t2_enc_tvalid", bus.enc_tvalid, 1);
        chk("t2_enc_tdata",  bus.enc_tdata,  PT);
        chk("t2_enc_tlast",  bus.enc_tlast,  1);
        chk("t2_s_tready",   bus.s_tready,   1);
        tick();
        bus.s_tvalid = 1'b0;
        chk("t2_inflight_1", inflight, 1);
        bus.enc_out_fire = 1'b1;
        tick();
        bus.enc_out_fire = 1'b0;
        chk("t2_inflight_0", inflight, 0);

        // ---- table-driven pass-through vectors ----
        for (int i = 0; i < 8; i++) begin
            d              = rnd128();
            bus.s_tvalid   = tbl[i].sv;
            bus.s_tlast    = tbl[i].sl;
            bus.enc_tready = tbl[i].er;
            bus.s_tdata    = d;
            #1;
            chk($sformatf("vec%0d_enc_tvalid", i), bus.enc_tvalid, tbl[i].ev);
            chk($sformatf("vec%0d_s_tready", i),   bus.s_tready,   tbl[i].sr);
            chk($sformatf("vec%0d_key_tready", i), bus.key_tready, tbl[i].kr);
            chk($sformatf("vec%0d_enc_tdata", i),  bus.enc_tdata,  d);
            chk($sformatf("vec%0d_enc_tlast", i),  bus.enc_tlast,  tbl[i].sl);
            tick();
        end
        bus.s_tvalid = 1'b0;
        chk("vec_inflight", inflight, 3);
        bus.enc_out_fire = 1'b1;
        repeat (3) tick();
        bus.enc_out_fire = 1'b0;
        chk("vec_inflight_drained", inflight, 0);

        // ---- T3: key offered mid-frame waits for tlast, then DRAIN ----
        k2             = {rnd128(), rnd128()};
        bus.enc_tready = 1'b1;
        bus.s_tvalid   = 1'b1;
        bus.s_tlast    = 1'b0;
        bus.s_tdata    = rnd128();
        #1;
        chk("t3_beat0_s_tready", bus.s_tready, 1);
        tick();
        bus.key_tdata  = k2;
        bus.key_tvalid = 1'b1;
        for (int b = 1; b < 4; b++) begin
            bus.s_tdata = rnd128();
            bus.s_tlast = (b == 3);
            #1;
            chk($sformatf("t3_beat%0d_key_tready", b), bus.key_tready, 0);
            chk($sformatf("t3_beat%0d_s_tready", b),   bus.s_tready,   1);
            tick();
        end
        bus.s_tvalid = 1'b0;
        #1;
        chk("t3_key_tready_after_tlast", bus.key_tready, 1);
        tick();
        bus.key_tvalid = 1'b0;
        chk("t3_state_drain",  dbg.state,     ST_DRAIN);
        chk("t3_inflight_4",   inflight,      4);
        chk("t3_old_key_kept", aes_key,       K1);
        chk("t3_loaded_drain", keys_loaded,   1);
        bus.s_tvalid = 1'b1;
        #1;
        chk("t3_drain_s_tready",   bus.s_tready,   0);
        chk("t3_drain_enc_tvalid", bus.enc_tvalid, 0);
        bus.s_tvalid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            bus.enc_out_fire = 1'b1;
            tick();
            chk($sformatf("t3_retire%0d_state", r),    dbg.state, ST_DRAIN);
            chk($sformatf("t3_retire%0d_inflight", r), inflight,  3 - r);
        end
        bus.enc_out_fire = 1'b0;
        tick();
        chk("t3_state_expand", dbg.state,     ST_EXPAND);
        chk("t3_new_key",      aes_key,       k2);
        chk("t3_key_valid_gap", aes_key_valid, 0);
        chk("t3_loaded_clear", keys_loaded,   0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t3_exp%0d_key_valid", i), aes_key_valid, 1);
            chk($sformatf("t3_exp%0d_loaded", i),    keys_loaded,   (i == 2));
        end
        chk("t3_state_run", dbg.state, ST_RUN);

        // ---- T4: engine output stalled, input stalls at 16 in flight ----
        bus.enc_tready = 1'b1;
        bus.s_tvalid   = 1'b1;
        bus.s_tlast    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.s_tdata = rnd128();
            #1;
            chk($sformatf("t4_cyc%0d_s_tready", c), bus.s_tready, (c < 16));
            tick();
        end
        chk("t4_inflight_full", inflight, 16);
        for (int k = 0; k < 4; k++) begin
            bus.enc_out_fire = 1'b1;
            #1;
            chk($sformatf("t4_ret%0d_s_tready_full", k), bus.s_tready, 0);
            tick();
            bus.enc_out_fire = 1'b0;
            chk($sformatf("t4_ret%0d_inflight_15", k), inflight, 15);
            #1;
            chk($sformatf("t4_ret%0d_s_tready_resume", k), bus.s_tready, 1);
            tick();
            chk($sformatf("t4_ret%0d_inflight_16", k), inflight, 16);
        end
        bus.s_tvalid     = 1'b0;
        bus.enc_out_fire = 1'b1;
        repeat (16) tick();
        bus.enc_out_fire = 1'b0;
        chk("t4_inflight_empty", inflight, 0);

        // ---- randomized traffic against a counting model ----
        m_inf      = 0;
        m_in_frame = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic sv, sl, er, of, gate, acc;
            sv = ($urandom_range(0, 9) < 8);
            er = ($urandom_range(0, 9) < 8);
            sl = ($urandom_range(0, 3) == 0);
            of = (m_inf > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
            d  = rnd128();
            bus.s_tvalid     = sv;
            bus.s_tlast      = sl;
            bus.enc_tready   = er;
            bus.enc_out_fire = of;
            bus.s_tdata      = d;
            #1;
            gate = (m_inf < 16);
            acc  = sv && er && gate;
            chk("rnd_s_tready",   bus.s_tready,   er && gate);
            chk("rnd_enc_tvalid", bus.enc_tvalid, sv && gate);
            chk("rnd_key_tready", bus.key_tready, !m_in_frame && !(acc && !sl));
            if (acc) exp_q.push_back({sl, d});
            if (bus.enc_tvalid && bus.enc_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rnd_sb_underflow: engine handshake with no expected beat");
                end else begin
                    chk("rnd_sb_beat", {bus.enc_tlast, bus.enc_tdata}, exp_q.pop_front());
                end
            end
            tick();
            if (acc && !of)                m_inf = m_inf + 1;
            else if (of && !acc && m_inf > 0) m_inf = m_inf - 1;
            if (acc) m_in_frame = !sl;
            chk("rnd_inflight", inflight, m_inf);
        end
        chk("rnd_sb_leftover", exp_q.size(), 0);
        idle_inputs();

        // ---- T5: expansion timeout ----
        resetn = 1'b0;
        tick();
        resetn         = 1'b1;
        rkv            = 1'b0;
        bus.key_tdata  = K1;
        bus.key_tvalid = 1'b1;
        tick();
        bus.key_tvalid = 1'b0;
        repeat (1023) tick();
        chk("t5_err_before", err_timeout, 0);
        chk("t5_state_before", dbg.state, ST_EXPAND);
        tick();
        chk("t5_err",         err_timeout,   1);
        chk("t5_state_idle",  dbg.state,     ST_IDLE);
        chk("t5_key_valid",   aes_key_valid, 0);
        bus.enc_tready = 1'b1;
        bus.s_tvalid   = 1'b1;
        #1;
        chk("t5_s_tready",   bus.s_tready,   0);
        chk("t5_key_tready", bus.key_tready, 1);
        bus.s_tvalid   = 1'b0;
        // Retry with a working expansion: error stays sticky.
        rkv            = 1'b1;
        bus.key_tvalid = 1'b1;
        tick();
        bus.key_tvalid = 1'b0;
        repeat (3) tick();
        chk("t5_reload_loaded", keys_loaded, 1);
        chk("t5_err_sticky",    err_timeout, 1);

        // ---- T6: async reset during DRAIN with 3 in flight ----
        bus.s_tvalid = 1'b1;
        bus.s_tlast  = 1'b1;
        repeat (3) begin
            bus.s_tdata = rnd128();
            tick();
        end
        bus.s_tvalid   = 1'b0;
        bus.key_tdata  = {rnd128(), rnd128()};
        bus.key_tvalid = 1'b1;
        tick();
        chk("t6_state_drain", dbg.state, ST_DRAIN);
        chk("t6_inflight_3",  inflight,  3);
        bus.s_tvalid = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        chk_reset("t6_async");
        tick();
        resetn = 1'b1;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "watchdog");
    end
endmodule
